semaphore_arbiter: RTL
======================

# semaphore_arbiter

Request front end for the semaphore counter register. Collects per-core TAKE (P, decrement) and GIVE (V, increment) requests, serialises them with a round-robin arbiter, and computes the next count value. Drives the count register's data input and write strobe, and returns a one-cycle acknowledge to the served core. Sits directly upstream of the semaphore unit: reads its current count and produces the value it loads.

## Interface
- NumberOfCores, 2, number of requesting cores (1..8)
- MaxCount, 15, saturation ceiling of the 4-bit count (1..15)

- CLK  input  1  system clock, all state on rising edge
- SEMAPHOREARB_nRESET  input  1  asynchronous, active-low reset
- SEMAPHOREARB_TAKE_REQ  input  NumberOfCores  per-core take request, level, held until ACK
- SEMAPHOREARB_GIVE_REQ  input  NumberOfCores  per-core give request, level, held until ACK
- SEMAPHOREARB_ACK  output  NumberOfCores  one-hot, one-cycle pulse: request of that core served
- SEMAPHOREARB_WAIT  output  NumberOfCores  core has TAKE pending while count is 0
- SEMAPHOREARB_CntIn  input  4  current count from the semaphore unit
- SEMAPHOREARB_CntOut  output  4  next count to the semaphore unit
- SEMAPHOREARB_WR  output  1  write strobe to the semaphore unit
- SEMAPHOREARB_OVERFLOW  output  1  sticky overflow flag (only with SEMAPHOREARB_OVERFLOW_EN)

## Operation
- FSM, two states: IDLE, COMMIT. Reset state IDLE.
- IDLE: form the eligible set. GIVE[i] is always eligible. TAKE[i] is eligible only if CntIn != 0. The core acked in the previous COMMIT is masked for this one IDLE cycle.
- Eligible set empty: stay IDLE.
- Otherwise pick the first eligible core at or after rr_ptr, wrapping modulo NumberOfCores. Register the core index and the operation, then go to COMMIT.
- Same core with both GIVE and TAKE eligible: GIVE served first. TAKE stays pending and competes in a later round.
- Next count: GIVE gives CntIn+1, saturating at MaxCount. TAKE gives CntIn-1 (never issued at 0). Arithmetic is 4-bit unsigned.
- COMMIT: WR=1, CntOut=next count, ACK[sel]=1 for exactly one cycle. rr_ptr becomes sel+1 mod NumberOfCores. Then go to IDLE.
- GIVE at CntIn==MaxCount: acked, WR=1 with CntOut=MaxCount (no change).
- WAIT[i] is registered: WAIT[i] <= TAKE_REQ[i] && CntIn==0. It updates every cycle in both states.
- Requester contract: drop the request the cycle after ACK; issue a new request no earlier than two cycles after ACK.
- Reset values: ACK=0, WAIT=0, WR=0, CntOut=0, OVERFLOW=0, rr_ptr=0, state IDLE.

## Timing
- Every output is registered.
- Request visible in cycle 0 → COMMIT in cycle 1 (WR, CntOut, ACK high). The unit loads on edge 2. CntIn is updated in cycle 2.
- Minimum request-to-ACK latency: 1 cycle.
- Maximum sustained throughput: one operation per 2 cycles.
- Worst-case wait for an eligible request: 2·NumberOfCores cycles.
- A TAKE blocked at count 0 has no latency bound until some GIVE is served.
- Reset asserted during COMMIT: WR and ACK drop asynchronously and the operation is lost. The requester must re-issue it after reset.
- Reset deasserted: first arbitration happens in the first cycle with nRESET high.

## Configuration
- SEMAPHOREARB_OVERFLOW_EN defined:
  - The SEMAPHOREARB_OVERFLOW port exists.
  - It is set in the COMMIT cycle of a GIVE served at CntIn==MaxCount.
  - It stays set until reset.
- Not defined: the port and its flop are absent. Saturation behaviour is identical.

## Test plan
- Reset, CntIn=0, TAKE_REQ=01 held 5 cycles → no ACK, WR=0, WAIT=01 from cycle 1.
- CntIn=3, TAKE_REQ=01 at cycle 0 → cycle 1: WR=1, CntOut=2, ACK=01. Cycle 2: ACK=00, WR=0.
- CntIn=5, GIVE_REQ=11 held (each core drops its request one cycle after its own ACK) → core 0 acked cycle 1 with CntOut=6. Core 1 acked cycle 3 (its CntIn=6), CntOut=7.
- CntIn=0, TAKE_REQ=01 and GIVE_REQ=10 → core 1 GIVE acked first with CntOut=1. Then core 0 TAKE acked with CntOut=0. WAIT[0] is 1 until the count reads 1.
- CntIn=15, GIVE_REQ=01 → ACK=01, CntOut=15. OVERFLOW=1 (macro on) and stays 1 through later traffic until nRESET=0.
- TAKE_REQ=01 with CntIn=4, nRESET pulled low during the COMMIT cycle → WR and ACK drop immediately, all outputs at reset values. After release, the held request is served with CntOut=3.

Source files
------------

// File: rtl/semaphore_arbiter.sv
// Round-robin TAKE/GIVE front end for the semaphore count register.
// Optional sticky overflow flag: define SEMAPHOREARB_OVERFLOW_EN.
module semaphore_arbiter #(
  parameter int NumberOfCores = 2,
  parameter int MaxCount      = 15
) (
  input  logic                     CLK,
  input  logic                     SEMAPHOREARB_nRESET,
  input  logic [NumberOfCores-1:0] SEMAPHOREARB_TAKE_REQ,
  input  logic [NumberOfCores-1:0] SEMAPHOREARB_GIVE_REQ,
  output logic [NumberOfCores-1:0] SEMAPHOREARB_ACK,
  output logic [NumberOfCores-1:0] SEMAPHOREARB_WAIT,
  input  logic [3:0]               SEMAPHOREARB_CntIn,
  output logic [3:0]               SEMAPHOREARB_CntOut,
  output logic                     SEMAPHOREARB_WR
`ifdef SEMAPHOREARB_OVERFLOW_EN
  ,
  output logic                     SEMAPHOREARB_OVERFLOW
`endif
);

  localparam int              IdxW    = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1;
  localparam logic [IdxW:0]   CoresW  = (IdxW+1)'(NumberOfCores);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumberOfCores - 1);
  localparam logic [3:0]      MaxCnt  = 4'(MaxCount);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]          sel_q, sel_d;
  logic [NumberOfCores-1:0] mask_q, mask_d;
  logic [NumberOfCores-1:0] ack_q, ack_d;
  logic [NumberOfCores-1:0] wait_q, wait_d;
  logic [3:0]               cnt_out_q, cnt_out_d;
  logic                     wr_q, wr_d;
`ifdef SEMAPHOREARB_OVERFLOW_EN
  logic                     ovf_q, ovf_d;
`endif

  logic                     cnt_nz_s;
  logic [NumberOfCores-1:0] eligible_s;
  logic                     found_s;
  logic                     hit_s;
  logic [IdxW-1:0]          pick_s;
  logic [IdxW:0]            scan_s;
  logic                     give_sel_s;
  logic [3:0]               cnt_next_s;

  function automatic logic [NumberOfCores-1:0] onehot(input logic [IdxW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Eligible set: GIVE always, TAKE only with a nonzero count; last served core sits out once.
  always_comb begin
    cnt_nz_s   = |SEMAPHOREARB_CntIn;
    eligible_s = (SEMAPHOREARB_GIVE_REQ | (SEMAPHOREARB_TAKE_REQ & {NumberOfCores{cnt_nz_s}}))
                 & ~mask_q;
  end

  // Scan from rr_ptr upward with wrap; first eligible core wins.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    pick_s  = '0;
    scan_s  = '0;
    for (int i = 0; i < NumberOfCores; i++) begin
      scan_s  = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      scan_s  = (scan_s >= CoresW) ? (scan_s - CoresW) : scan_s;
      hit_s   = ~found_s & eligible_s[scan_s[IdxW-1:0]];
      pick_s  = hit_s ? scan_s[IdxW-1:0] : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // GIVE wins over TAKE on the same core; GIVE saturates at the ceiling.
  always_comb begin
    give_sel_s = SEMAPHOREARB_GIVE_REQ[pick_s];
    if (give_sel_s) begin
      cnt_next_s = (SEMAPHOREARB_CntIn >= MaxCnt) ? MaxCnt : (SEMAPHOREARB_CntIn + 4'd1);
    end else begin
      cnt_next_s = SEMAPHOREARB_CntIn - 4'd1;
    end
  end

  // Next-state and registered-output logic of the IDLE/COMMIT machine.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    ack_d     = '0;
    wr_d      = 1'b0;
    cnt_out_d = cnt_out_q;
    wait_d    = SEMAPHOREARB_TAKE_REQ & {NumberOfCores{~cnt_nz_s}};
`ifdef SEMAPHOREARB_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        mask_d = '0;
        if (found_s) begin
          state_d   = ST_COMMIT;
          sel_d     = pick_s;
          ack_d     = onehot(pick_s);
          wr_d      = 1'b1;
          cnt_out_d = cnt_next_s;
`ifdef SEMAPHOREARB_OVERFLOW_EN
          ovf_d     = ovf_q | (give_sel_s & (SEMAPHOREARB_CntIn == MaxCnt));
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (sel_q == LastIdx) ? '0 : (sel_q + IdxW'(1));
        mask_d   = onehot(sel_q);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge SEMAPHOREARB_nRESET) begin
    if (!SEMAPHOREARB_nRESET) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      mask_q    <= '0;
      ack_q     <= '0;
      wait_q    <= '0;
      cnt_out_q <= 4'd0;
      wr_q      <= 1'b0;
`ifdef SEMAPHOREARB_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
      wait_q    <= wait_d;
      cnt_out_q <= cnt_out_d;
      wr_q      <= wr_d;
`ifdef SEMAPHOREARB_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign SEMAPHOREARB_ACK    = ack_q;
  assign SEMAPHOREARB_WAIT   = wait_q;
  assign SEMAPHOREARB_CntOut = cnt_out_q;
  assign SEMAPHOREARB_WR     = wr_q;
`ifdef SEMAPHOREARB_OVERFLOW_EN
  assign SEMAPHOREARB_OVERFLOW = ovf_q;
`endif

endmodule
